// File: rtl/shift_req_queue.sv
// Request FIFO in front of an external combinational left barrel shifter,
// with a registered, back-pressurable result stage behind it.
module shift_req_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AMT_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [AMT_W-1:0]         in_amount,
  output logic [DATA_W-1:0]        sh_data,
  output logic [AMT_W-1:0]         sh_control,
  input  logic [DATA_W-1:0]        sh_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [AMT_W-1:0]         out_amount,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [AMT_W-1:0]  mem_amt  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [AMT_W-1:0]  out_amount_q, out_amount_d;

  logic push, pop, empty, out_free;

  // Handshake decode and next-state for pointers, occupancy and result stage
  always_comb begin
    empty        = (level_q == LVL_W'(0));
    in_ready     = (level_q != LVL_W'(DEPTH));
    out_free     = !out_valid_q || out_ready;
    push         = in_valid && in_ready;
    pop          = !empty && out_free;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_amount_d = out_amount_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // An empty FIFO with a free output stage drains out_valid
    if (out_free) out_valid_d = pop;
    if (pop) begin
      out_data_d   = sh_result;
      out_amount_d = mem_amt[rd_ptr_q];
    end
  end

  // Shifter inputs are zeroed when there is no head entry
  always_comb begin
    sh_data    = DATA_W'(0);
    sh_control = AMT_W'(0);
    if (!empty) begin
      sh_data    = mem_data[rd_ptr_q];
      sh_control = mem_amt[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_amount_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_amount_q <= out_amount_d;
    end
  end

  // Storage carries no reset; occupancy alone says what is live
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_amt[wr_ptr_q]  <= in_amount;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_amount = out_amount_q;
  assign level      = level_q;

endmodule

// File: tb/tb_shift_req_queue.sv
// Directed bench for shift_req_queue with a behavioural left-shifter model.
module tb_shift_req_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amount;
  logic [15:0] sh_data;
  logic [3:0]  sh_control;
  logic [15:0] sh_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_amount;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  amt;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[5];
  logic [15:0] drain_exp[5];
  logic [19:0] sb[$];

  always #5 clk = ~clk;

  assign sh_result = sh_data << sh_control;

  shift_req_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amount  (in_amount),
    .sh_data    (sh_data),
    .sh_control (sh_control),
    .sh_result  (sh_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_amount (out_amount),
    .level      (level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n requests and checks every transfer against a scoreboard
  task automatic run_stream(input int n, input bit toggle, input logic [15:0] base);
    int sent = 0;
    int recv = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    bit hold_pending = 1'b0;
    logic [15:0] hold_data = '0;
    logic [3:0]  hold_amt = '0;
    logic [19:0] e;
    for (int cyc = 0; cyc < 200 && recv < n; cyc++) begin
      in_valid  = (sent < n);
      in_data   = base + 16'(sent);
      in_amount = toggle ? 4'((sent * 3) % 16) : 4'(sent % 16);
      out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      #1;
      if (hold_pending) begin
        check("hold_valid", 32'(out_valid), 32'(1'b1));
        check("hold_data", 32'(out_data), 32'(hold_data));
        check("hold_amt", 32'(out_amount), 32'(hold_amt));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_result", 32'(1'b1), 32'(1'b0));
        end else begin
          e = sb.pop_front();
          check("stream_data", 32'(out_data), 32'(e[19:4]));
          check("stream_amt", 32'(out_amount), 32'(e[3:0]));
        end
        recv++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      hold_amt     = out_amount;
      if (in_valid && in_ready) begin
        sb.push_back({16'(in_data << in_amount), in_amount});
        sent++;
      end
      if (!toggle) check("stream_level_le1", 32'(level <= 3'd1), 32'(1'b1));
      step();
    end
    in_valid = 1'b0;
    check("stream_count", 32'(recv), 32'(n));
    if (!toggle) check("stream_back_to_back", 32'(last_cyc - first_cyc), 32'(n - 1));
    #1;
    check("stream_sb_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    vecs[0] = '{data: 16'h0001, amt: 4'd3,  exp: 16'h0008};
    vecs[1] = '{data: 16'hA5A5, amt: 4'd0,  exp: 16'hA5A5};
    vecs[2] = '{data: 16'hFFFF, amt: 4'd15, exp: 16'h8000};
    vecs[3] = '{data: 16'h8001, amt: 4'd1,  exp: 16'h0002};
    vecs[4] = '{data: 16'h1234, amt: 4'd4,  exp: 16'h2340};
    drain_exp[0] = 16'h0001;
    drain_exp[1] = 16'h0002;
    drain_exp[2] = 16'h0004;
    drain_exp[3] = 16'h0008;
    drain_exp[4] = 16'h0010;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amount = '0; out_ready = 1'b0;
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("rst_level", 32'(level), 32'(3'd0));
    check("rst_in_ready", 32'(in_ready), 32'(1'b1));
    check("rst_out_data", 32'(out_data), 32'(16'h0));
    check("rst_sh_data", 32'(sh_data), 32'(16'h0));
    rst_n = 1'b1;
    step();

    // Single request per vector: accept, then result one edge later
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = vecs[i].data; in_amount = vecs[i].amt; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("vec_level_after_push", 32'(level), 32'(3'd1));
      check("vec_sh_data", 32'(sh_data), 32'(vecs[i].data));
      check("vec_sh_control", 32'(sh_control), 32'(vecs[i].amt));
      check("vec_out_valid_early", 32'(out_valid), 32'(1'b0));
      step();
      check("vec_out_valid", 32'(out_valid), 32'(1'b1));
      check("vec_out_data", 32'(out_data), 32'(vecs[i].exp));
      check("vec_out_amount", 32'(out_amount), 32'(vecs[i].amt));
      check("vec_level_after_pop", 32'(level), 32'(3'd0));
      check("vec_sh_data_empty", 32'(sh_data), 32'(16'h0));
      step();
      check("vec_out_valid_clear", 32'(out_valid), 32'(1'b0));
    end

    // Fill under back-pressure, reject when full, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'h0001; in_amount = 4'(i);
      step();
    end
    check("full_level", 32'(level), 32'(3'd4));
    check("full_in_ready", 32'(in_ready), 32'(1'b0));
    check("full_out_valid", 32'(out_valid), 32'(1'b1));
    check("full_out_data", 32'(out_data), 32'(16'h0001));
    in_data = 16'h7777; in_amount = 4'd5;
    step();
    check("full_reject_level", 32'(level), 32'(3'd4));
    check("full_reject_out_data", 32'(out_data), 32'(16'h0001));
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain_valid", 32'(out_valid), 32'(1'b1));
      check("drain_data", 32'(out_data), 32'(drain_exp[k]));
      check("drain_amount", 32'(out_amount), 32'(k));
      step();
    end
    check("drain_done_valid", 32'(out_valid), 32'(1'b0));
    check("drain_done_level", 32'(level), 32'(3'd0));

    run_stream(20, 1'b0, 16'h0001);
    step(); step();
    run_stream(8, 1'b1, 16'h0100);
    out_ready = 1'b1;
    step(); step();

    // Asynchronous reset between edges with work in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'h0F00 + 16'(i); in_amount = 4'd1;
      step();
    end
    in_valid = 1'b0;
    check("prerst_level", 32'(level), 32'(3'd3));
    check("prerst_out_valid", 32'(out_valid), 32'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'(1'b0));
    check("arst_level", 32'(level), 32'(3'd0));
    check("arst_out_data", 32'(out_data), 32'(16'h0));
    check("arst_out_amount", 32'(out_amount), 32'(4'h0));
    step();
    #2;
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'(1'b1));
    step();
    in_valid = 1'b1; in_data = 16'h0003; in_amount = 4'd2; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("postrst_out_valid", 32'(out_valid), 32'(1'b1));
    check("postrst_out_data", 32'(out_data), 32'(16'h000C));
    check("postrst_out_amount", 32'(out_amount), 32'(4'd2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
